note_timer: RTL and testbench
=============================

// Module: note_timer
// PURPOSE
//   Consumes the 1-cycle beat pulse from the beat generator and times how
//   long each note sounds. Holds the current note, counts its duration down
//   in beats, and pulses done_with_note so the upstream song reader can
//   fetch the next note. Sits between the beat generator and song reader
//   (upstream) and the note/tone generator (downstream).
// PARAMETERS
//   NOTE_W  6  width of note code; 0 = rest/silence
//   DUR_W   6  width of duration field, in beats (max 2^DUR_W-1)
// PORTS
//   clock           in   1       system clock, all logic on rising edge
//   reset           in   1       synchronous, active-low; 0 = reset
//   play            in   1       1 = counting enabled; 0 = pause
//   beat            in   1       1-cycle pulse from beat generator
//   load_new_note   in   1       1-cycle strobe: latch note_in/duration_in
//   note_in         in   NOTE_W  note code to play
//   duration_in     in   DUR_W   note length in beats
//   note_out        out  NOTE_W  note currently sounding; 0 when not playing
//   playing         out  1       1 while a note is active (state RUN)
//   beats_left      out  DUR_W   remaining beats of current note
//   done_with_note  out  1       1-cycle pulse: current note finished
// BEHAVIOUR
// - All outputs registered. Reset (reset==0 at clock edge): state IDLE,
//   note_out=0, playing=0, beats_left=0, done_with_note=0. Reset wins over
//   every other input, including mid-note; no done pulse is produced.
// - FSM states: IDLE, RUN, DONE.
//   IDLE: outputs quiescent. load_new_note -> RUN (or DONE if dur==0).
//   RUN : playing=1, note_out=latched note. beat&&play decrements
//         beats_left. Decrement from 1 -> 0 => DONE.
//   DONE: one cycle only; done_with_note=1, playing=0, note_out=0,
//         beats_left=0; then IDLE unless load_new_note (see below).
// - Load: on edge with load_new_note=1, next cycle note_out=note_in,
//   beats_left=duration_in, playing=1 (1-cycle latency). Accepted in any
//   state; in RUN it retriggers (old note abandoned, no done pulse).
// - duration_in==0: note not played; next cycle goes directly to DONE
//   (done_with_note=1, playing=0, note_out=0).
// - Load in DONE: done pulse still occurs this cycle; next cycle RUN with
//   the new note (back-to-back notes, no IDLE gap).
// - Load coincident with the final beat in RUN: load wins; no done pulse,
//   new note starts with its full duration.
// - play=0: beats ignored and not queued; beats_left, note_out held;
//   playing stays 1. Loads are still accepted while paused.
// - beat arriving in IDLE or DONE is ignored.
// - beats_left never wraps: decrement only when >0 in RUN.
// - done_with_note is never high two consecutive cycles.
// TESTING
// 1 Reset: hold reset=0 3 cycles with load/beat toggling -> all outputs 0;
//   release -> IDLE, outputs stay 0 until a load.
// 2 Basic note: play=1, load note_in=6'd12 dur=3, then 3 beats 32 cycles
//   apart -> note_out=12, playing=1, beats_left 3,2,1; after 3rd beat
//   done_with_note=1 one cycle, note_out=0, playing=0.
// 3 Pause: load dur=2, one beat -> beats_left=1; play=0 + 4 beats ->
//   beats_left stays 1; play=1 + 1 beat -> done pulse.
// 4 Retrigger: load note 5 dur 4, 2 beats, load note 9 dur 2 on same cycle
//   as a beat -> note_out=9, beats_left=2, no done pulse.
// 5 Zero duration and back-to-back: load dur=0 -> done next cycle,
//   playing never 1; load in DONE cycle (note 7 dur 1) -> RUN next cycle,
//   one beat -> second done pulse.
// 6 Reset mid-note: load dur=5, 2 beats, reset=0 one cycle -> outputs 0,
//   no done pulse, later beats ignored.

Source files
------------

// File: rtl/note_timer.sv
// Note duration timer: latches a note from the song reader, counts it down on
// beat pulses, and emits a single-cycle done_with_note when the note ends.
module note_timer #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  duration_in,
  output logic [NOTE_W-1:0] note_out,
  output logic              playing,
  output logic [DUR_W-1:0]  beats_left,
  output logic              done_with_note
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic               playing_d, done_d;

  // State and datapath registers. The note and count are forced to zero
  // outside RUN, so they drive the outputs directly.
  always_ff @(posedge clock) begin
    // NOTE: reset is sampled on the clock edge only (synchronous, active-low).
    if (!reset) begin
      state_q        <= IDLE;
      note_q         <= '0;
      cnt_q          <= '0;
      playing        <= 1'b0;
      done_with_note <= 1'b0;
    end else begin
      state_q        <= state_d;
      note_q         <= note_d;
      cnt_q          <= cnt_d;
      playing        <= playing_d;
      done_with_note <= done_d;
    end
  end

  // Next-state logic. A load overrides whatever the current note is doing,
  // including a coincident final beat.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    state_d = state_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    if (load_new_note) begin
      if (duration_in != '0) begin
        state_d = RUN;
        note_d  = note_in;
        cnt_d   = duration_in;
      end else begin
        // A zero-length note finishes immediately; if a done pulse is already
        // in flight it doubles as this note's completion, keeping pulses apart.
        state_d = (state_q == DONE) ? IDLE : DONE;
        note_d  = '0;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (beat && play && cnt_q != '0) begin
            if (cnt_q == DUR_W'(1)) begin
              state_d = DONE;
              note_d  = '0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - DUR_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: begin
          state_d = IDLE;
          note_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state, registered above.
  always_comb begin
    playing_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  assign note_out   = note_q;
  assign beats_left = cnt_q;

endmodule

// File: tb/tb_note_timer.sv
// Directed bench for note_timer: reset, countdown, pause, retrigger,
// zero-length and back-to-back notes, and reset in the middle of a note.
module tb_note_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic       play;
  logic       beat;
  logic       load_new_note;
  logic [5:0] note_in;
  logic [5:0] duration_in;
  logic [5:0] note_out;
  logic       playing;
  logic [5:0] beats_left;
  logic       done_with_note;

  int n_cmp = 0;
  int n_err = 0;

  wire [13:0] obs = {note_out, playing, beats_left, done_with_note};

  note_timer #(.NOTE_W(6), .DUR_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .play           (play),
    .beat           (beat),
    .load_new_note  (load_new_note),
    .note_in        (note_in),
    .duration_in    (duration_in),
    .note_out       (note_out),
    .playing        (playing),
    .beats_left     (beats_left),
    .done_with_note (done_with_note)
  );

  always #5 clock = ~clock;

  function automatic logic [13:0] pack(input logic [5:0] n, input logic p,
                                       input logic [5:0] b, input logic d);
    return {n, p, b, d};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d);
    note_in = n; duration_in = d; load_new_note = 1'b1;
    tick();
    load_new_note = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    reset = 1'b0; play = 1'b1; note_in = 6'd5; duration_in = 6'd3;
    for (int i = 0; i < 3; i++) begin
      load_new_note = i[0]; beat = ~i[0];
      tick();
      e = pack(0, 0, 0, 0);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL reset_hold[%0d] got=%h want=%h", i, obs, e); end
    end
    load_new_note = 1'b0; beat = 1'b0; reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = pack(0, 0, 0, 0);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL reset_release[%0d] got=%h want=%h", i, obs, e); end
    end
  endtask

  task automatic test_basic();
    logic [13:0] e;
    play = 1'b1;
    load(6'd12, 6'd3);
    e = pack(12, 1, 3, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL basic_load got=%h want=%h", obs, e); end
    for (int k = 0; k < 3; k++) begin
      repeat (31) tick();
      e = pack(12, 1, 6'(3 - k), 0);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL basic_wait[%0d] got=%h want=%h", k, obs, e); end
      pulse_beat();
      e = (k == 2) ? pack(0, 0, 0, 1) : pack(12, 1, 6'(2 - k), 0);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL basic_beat[%0d] got=%h want=%h", k, obs, e); end
    end
    tick();
    e = pack(0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL basic_idle got=%h want=%h", obs, e); end
    pulse_beat();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL beat_in_idle got=%h want=%h", obs, e); end
  endtask

  task automatic test_pause();
    logic [13:0] e;
    play = 1'b1;
    load(6'd3, 6'd2);
    pulse_beat();
    e = pack(3, 1, 1, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL pause_first got=%h want=%h", obs, e); end
    play = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse_beat();
      tick();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL pause_hold[%0d] got=%h want=%h", i, obs, e); end
    end
    play = 1'b1;
    pulse_beat();
    e = pack(0, 0, 0, 1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL pause_done got=%h want=%h", obs, e); end
    tick();
    e = pack(0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL pause_idle got=%h want=%h", obs, e); end
  endtask

  task automatic test_retrigger();
    logic [13:0] e;
    play = 1'b1;
    load(6'd5, 6'd4);
    pulse_beat();
    pulse_beat();
    e = pack(5, 1, 2, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL retrig_pre got=%h want=%h", obs, e); end
    beat = 1'b1;
    load(6'd9, 6'd2);
    beat = 1'b0;
    e = pack(9, 1, 2, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL retrig_load got=%h want=%h", obs, e); end
    pulse_beat();
    e = pack(9, 1, 1, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL retrig_beat got=%h want=%h", obs, e); end
    // Load coincident with the final beat: no done pulse, full new duration.
    beat = 1'b1;
    load(6'd11, 6'd3);
    beat = 1'b0;
    e = pack(11, 1, 3, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL final_beat_load got=%h want=%h", obs, e); end
    for (int k = 0; k < 3; k++) begin
      pulse_beat();
      e = (k == 2) ? pack(0, 0, 0, 1) : pack(11, 1, 6'(2 - k), 0);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL retrig_drain[%0d] got=%h want=%h", k, obs, e); end
    end
    tick();
    e = pack(0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL retrig_idle got=%h want=%h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] e;
    play = 1'b1;
    load(6'd4, 6'd0);
    e = pack(0, 0, 0, 1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL zero_dur_done got=%h want=%h", obs, e); end
    load(6'd7, 6'd1);
    e = pack(7, 1, 1, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL b2b_run got=%h want=%h", obs, e); end
    pulse_beat();
    e = pack(0, 0, 0, 1);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL b2b_done got=%h want=%h", obs, e); end
    tick();
    e = pack(0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL b2b_idle got=%h want=%h", obs, e); end
  endtask

  task automatic test_reset_mid_note();
    logic [13:0] e;
    play = 1'b1;
    load(6'd2, 6'd5);
    pulse_beat();
    pulse_beat();
    e = pack(2, 1, 3, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL mid_pre got=%h want=%h", obs, e); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    e = pack(0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL mid_reset got=%h want=%h", obs, e); end
    for (int i = 0; i < 3; i++) begin
      pulse_beat();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL mid_after[%0d] got=%h want=%h", i, obs, e); end
    end
  endtask

  initial begin
    reset = 1'b0; play = 1'b0; beat = 1'b0; load_new_note = 1'b0;
    note_in = '0; duration_in = '0;
    #1;
    test_reset();
    test_basic();
    test_pause();
    test_retrigger();
    test_back_to_back();
    test_reset_mid_note();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
